return_address_stack: RTL and testbench

Parametrised return-address stack (RAS) for the MIPS pipeline's decode-stage jump logic. JAL/JALR with rd=$31 push the link address. JR $31 pops it to give an early predicted target. The storage is a circular buffer of configurable depth with overflow wrap-around, sticky fault flags, a flush, and a debug read port so the debug unit can dump the stack alongside registers and data memory. All state advances only when the pipeline steps (`i_step`).

---
 rtl/return_address_stack_pkg.sv | 21 ++
 rtl/return_address_stack_if.sv | 31 +++
 rtl/return_address_stack_storage.sv | 33 +++
 rtl/return_address_stack.sv | 116 +++++++++++
 tb/tb_return_address_stack.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/return_address_stack_pkg.sv
// Shared definitions for the return-address stack and the decode logic
// that generates its push/pop requests.
package return_address_stack_pkg;

  localparam int RAS_DEPTH_DEFAULT = 8;
  localparam logic [4:0] RAS_LINK_REG = 5'd31;

  // Operation selected on a stepping cycle once flush has been ruled out.
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } ras_op_e;

  // Decode helper: a JAL/JALR/JR touches the stack only through $31.
  function automatic logic is_link_reg(input logic [4:0] rd);
    return rd == RAS_LINK_REG;
  endfunction

endpackage

// File: rtl/return_address_stack_if.sv
// Request/response bundle between decode/debug and the return-address stack.
interface return_address_stack_if #(
  parameter int NB    = 32,
  parameter int DEPTH = 8
);
  localparam int NB_PTR   = $clog2(DEPTH);
  localparam int NB_COUNT = $clog2(DEPTH) + 1;

  logic                i_step;
  logic                i_push;
  logic [NB-1:0]       i_push_address;
  logic                i_pop;
  logic                i_flush;
  logic [NB_PTR-1:0]   i_debug_depth;
  logic [NB-1:0]       o_top_address;
  logic                o_valid;
  logic [NB_COUNT-1:0] o_count;
  logic                o_overflow;
  logic                o_underflow;
  logic [NB-1:0]       o_debug_entry;

  modport master (
    output i_step, i_push, i_push_address, i_pop, i_flush, i_debug_depth,
    input  o_top_address, o_valid, o_count, o_overflow, o_underflow, o_debug_entry
  );

  modport slave (
    input  i_step, i_push, i_push_address, i_pop, i_flush, i_debug_depth,
    output o_top_address, o_valid, o_count, o_overflow, o_underflow, o_debug_entry
  );
endinterface

// File: rtl/return_address_stack_storage.sv
// Circular entry array: one synchronous write port, two combinational
// read ports (top and debug), cleared on reset.
module ras_storage #(
  parameter int NB     = 32,
  parameter int DEPTH  = 8,
  parameter int NB_PTR = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [NB_PTR-1:0] i_widx,
  input  logic [NB-1:0]     i_wdata,
  input  logic [NB_PTR-1:0] i_top_idx,
  input  logic [NB_PTR-1:0] i_dbg_idx,
  output logic [NB-1:0]     o_top,
  output logic [NB-1:0]     o_dbg
);

  logic [NB-1:0] mem_q [DEPTH];

  // Entry array write / clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (i_we) begin
      mem_q[i_widx] <= i_wdata;
    end
  end

  assign o_top = mem_q[i_top_idx];
  assign o_dbg = mem_q[i_dbg_idx];

endmodule

// File: rtl/return_address_stack.sv
// Return-address stack for decode-stage jump prediction. Holds the write
// pointer, occupancy and sticky fault flags; entries live in ras_storage.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int NB    = 32,
  parameter int DEPTH = RAS_DEPTH_DEFAULT
) (
  input logic                    i_clk,
  input logic                    i_reset,
  return_address_stack_if.slave  bus
);

  localparam int NB_PTR   = $clog2(DEPTH);
  localparam int NB_COUNT = $clog2(DEPTH) + 1;
  localparam logic [NB_COUNT-1:0] FULL = NB_COUNT'(DEPTH);

  logic [NB_PTR-1:0]   wp_q, wp_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic                we;
  logic [NB_PTR-1:0]   widx;
  logic [NB_PTR-1:0]   top_idx;
  logic [NB_PTR-1:0]   dbg_idx;
  logic [NB-1:0]       top_raw;
  logic [NB-1:0]       dbg_raw;
  logic                empty;
  ras_op_e             op;

  assign empty   = (count_q == '0);
  assign top_idx = wp_q - NB_PTR'(1);
  assign dbg_idx = wp_q - NB_PTR'(1) - bus.i_debug_depth;
  assign op      = ras_op_e'({bus.i_push, bus.i_pop});

  ras_storage #(.NB(NB), .DEPTH(DEPTH), .NB_PTR(NB_PTR)) u_storage (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we      (we),
    .i_widx    (widx),
    .i_wdata   (bus.i_push_address),
    .i_top_idx (top_idx),
    .i_dbg_idx (dbg_idx),
    .o_top     (top_raw),
    .o_dbg     (dbg_raw)
  );

  // Next-state for pointer, occupancy, flags and the entry write request.
  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    we      = 1'b0;
    widx    = wp_q;
    if (bus.i_step) begin
      if (bus.i_flush) begin
        wp_d    = '0;
        count_d = '0;
      end else begin
        case (op)
          OP_PUSH: begin
            we   = 1'b1;
            wp_d = wp_q + NB_PTR'(1);
            if (count_q == FULL) ovf_d   = 1'b1;
            else                 count_d = count_q + NB_COUNT'(1);
          end
          OP_POP: begin
            if (empty) begin
              udf_d = 1'b1;
            end else begin
              wp_d    = wp_q - NB_PTR'(1);
              count_d = count_q - NB_COUNT'(1);
            end
          end
          OP_REPLACE: begin
            we = 1'b1;
            if (empty) begin
              // Return with nothing stacked: the call still records its link.
              udf_d   = 1'b1;
              wp_d    = wp_q + NB_PTR'(1);
              count_d = count_q + NB_COUNT'(1);
            end else begin
              widx = top_idx;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Control state register; reset dominates the step enable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.o_top_address = empty ? '0 : top_raw;
  assign bus.o_valid       = !empty;
  assign bus.o_count       = count_q;
  assign bus.o_overflow    = ovf_q;
  assign bus.o_underflow   = udf_q;
  assign bus.o_debug_entry = ({1'b0, bus.i_debug_depth} < count_q) ? dbg_raw : '0;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed bench for return_address_stack with DEPTH=4, NB=32.
module tb_return_address_stack;

  logic clk = 1'b0;
  logic rst;
  int   nchk  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  return_address_stack_if #(.NB(32), .DEPTH(4)) bus ();

  return_address_stack #(.NB(32), .DEPTH(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_push = 1'b0;
    bus.i_pop = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] a);
    bus.i_push = 1'b1; bus.i_push_address = a;
    tick();
    idle();
  endtask

  task automatic pop();
    bus.i_pop = 1'b1;
    tick();
    idle();
  endtask

  task automatic push_pop(input logic [31:0] a);
    bus.i_push = 1'b1; bus.i_pop = 1'b1; bus.i_push_address = a;
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_step = 1'b1;
    bus.i_push_address = '0;
    bus.i_debug_depth = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_top", bus.o_top_address, 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_count", 32'(bus.o_count), 32'h0);
    check("rst_ovf", 32'(bus.o_overflow), 32'h0);
    check("rst_udf", 32'(bus.o_underflow), 32'h0);
    check("rst_dbg", bus.o_debug_entry, 32'h0);

    // Basic LIFO
    push(32'h18);
    push(32'h40);
    check("lifo_top", bus.o_top_address, 32'h40);
    check("lifo_count", 32'(bus.o_count), 32'd2);
    check("lifo_valid", 32'(bus.o_valid), 32'h1);
    bus.i_debug_depth = 2'd1; #1;
    check("lifo_dbg1", bus.o_debug_entry, 32'h18);
    bus.i_debug_depth = 2'd2; #1;
    check("lifo_dbg2_oor", bus.o_debug_entry, 32'h0);
    bus.i_debug_depth = 2'd0;
    pop();
    check("lifo_pop1_top", bus.o_top_address, 32'h18);
    check("lifo_pop1_count", 32'(bus.o_count), 32'd1);
    pop();
    check("lifo_pop2_top", bus.o_top_address, 32'h0);
    check("lifo_pop2_valid", 32'(bus.o_valid), 32'h0);
    check("lifo_ovf", 32'(bus.o_overflow), 32'h0);
    check("lifo_udf", 32'(bus.o_underflow), 32'h0);

    // Overflow wrap
    do_reset();
    push(32'h10); push(32'h20); push(32'h30); push(32'h40);
    check("ovf_full_noflag", 32'(bus.o_overflow), 32'h0);
    push(32'h50);
    check("ovf_count", 32'(bus.o_count), 32'd4);
    check("ovf_top", bus.o_top_address, 32'h50);
    check("ovf_flag", 32'(bus.o_overflow), 32'h1);
    bus.i_debug_depth = 2'd3; #1;
    check("ovf_dbg3", bus.o_debug_entry, 32'h20);
    bus.i_debug_depth = 2'd1; #1;
    check("ovf_dbg1", bus.o_debug_entry, 32'h40);
    bus.i_debug_depth = 2'd0;
    check("ovf_ret0", bus.o_top_address, 32'h50);
    pop();
    bus.i_debug_depth = 2'd3; #1;
    check("ovf_dbg3_stale", bus.o_debug_entry, 32'h0);
    bus.i_debug_depth = 2'd0;
    check("ovf_ret1", bus.o_top_address, 32'h40);
    pop();
    check("ovf_ret2", bus.o_top_address, 32'h30);
    pop();
    check("ovf_ret3", bus.o_top_address, 32'h20);
    pop();
    check("ovf_empty_count", 32'(bus.o_count), 32'd0);
    check("ovf_empty_valid", 32'(bus.o_valid), 32'h0);
    check("ovf_no_udf", 32'(bus.o_underflow), 32'h0);

    // Underflow and simultaneous push/pop
    do_reset();
    pop();
    check("udf_flag", 32'(bus.o_underflow), 32'h1);
    check("udf_count", 32'(bus.o_count), 32'd0);
    push(32'h24);
    push_pop(32'h60);
    check("repl_count", 32'(bus.o_count), 32'd1);
    check("repl_top", bus.o_top_address, 32'h60);
    pop();
    check("repl_pop_count", 32'(bus.o_count), 32'd0);
    do_reset();
    push_pop(32'h77);
    check("pp_empty_count", 32'(bus.o_count), 32'd1);
    check("pp_empty_top", bus.o_top_address, 32'h77);
    check("pp_empty_udf", 32'(bus.o_underflow), 32'h1);

    // Step freeze
    do_reset();
    push(32'h18);
    bus.i_step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin bus.i_push = 1'b1; bus.i_push_address = 32'h99; end
      else bus.i_pop = 1'b1;
      bus.i_flush = (i == 4);
      tick();
      idle();
    end
    check("frz_top", bus.o_top_address, 32'h18);
    check("frz_count", 32'(bus.o_count), 32'd1);
    bus.i_step = 1'b1;
    push(32'h2C);
    check("frz_resume_count", 32'(bus.o_count), 32'd2);
    check("frz_resume_top", bus.o_top_address, 32'h2C);

    // Flush vs. flags
    do_reset();
    for (int i = 1; i <= 5; i++) push(32'(i));
    check("fl_pre_ovf", 32'(bus.o_overflow), 32'h1);
    bus.i_flush = 1'b1; bus.i_push = 1'b1; bus.i_push_address = 32'hAA;
    tick();
    idle();
    check("fl_count", 32'(bus.o_count), 32'd0);
    check("fl_valid", 32'(bus.o_valid), 32'h0);
    check("fl_top", bus.o_top_address, 32'h0);
    check("fl_ovf_sticky", 32'(bus.o_overflow), 32'h1);
    push(32'h8);
    check("fl_push_top", bus.o_top_address, 32'h8);
    check("fl_push_count", 32'(bus.o_count), 32'd1);

    // Reset mid-operation
    do_reset();
    pop();
    push(32'h11); push(32'h22); push(32'h33); push(32'h44); push(32'h55);
    check("rm_pre_udf", 32'(bus.o_underflow), 32'h1);
    rst = 1'b1; bus.i_push = 1'b1; bus.i_push_address = 32'hEE;
    tick();
    rst = 1'b0;
    idle();
    bus.i_debug_depth = 2'd0; #1;
    check("rm_top", bus.o_top_address, 32'h0);
    check("rm_count", 32'(bus.o_count), 32'd0);
    check("rm_valid", 32'(bus.o_valid), 32'h0);
    check("rm_ovf", 32'(bus.o_overflow), 32'h0);
    check("rm_udf", 32'(bus.o_underflow), 32'h0);
    check("rm_dbg", bus.o_debug_entry, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
